// File: rtl/mem_stage_access_unit.sv
// MEM stage load/store unit: req/ack data-memory port, big-endian lane alignment, MEM/WB register.
// Optional MEM_ALIGN_TRAP_EN: trap misaligned half/word accesses instead of masking low address bits.
module mem_stage_access_unit #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              R,
    input  logic              E_mem,
    input  logic              rw_dm_mem,
    input  logic [1:0]        size_mem,
    input  logic              se_mem,
    input  logic              load_mem,
    input  logic              rf_le_mem,
    input  logic [4:0]        mem_rd,
    input  logic [31:0]       alu_out_mem,
    input  logic [31:0]       st_data_mem,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-3:0] dm_addr,
    output logic [3:0]        dm_be,
    output logic [31:0]       dm_wdata,
    input  logic              dm_ack,
    input  logic [31:0]       dm_rdata,
    output logic              stall_mem,
    output logic              wb_rf_le,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              trap_misalign,
    output logic              err_bus
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [7:0]  timer;
    logic [1:0]  a_raw, a;
    logic        misalign, trap_now, issue, timeout_hit;
    logic [3:0]  be;
    logic [31:0] wdata, ext;
    logic [7:0]  lane8;
    logic [15:0] lane16;

    assign a_raw = alu_out_mem[1:0];

    always_comb begin
        misalign = 1'b0;
        a        = a_raw;
`ifdef MEM_ALIGN_TRAP_EN
        misalign = (size_mem == 2'b01 && a_raw[0]) || (size_mem[1] && a_raw != 2'b00);
`else
        case (size_mem)
            2'b00:   a = a_raw;
            2'b01:   a = {a_raw[1], 1'b0};
            default: a = 2'b00;
        endcase
`endif
    end

    // Big-endian lanes: byte offset 0 lives in bits [31:24].
    always_comb begin
        case (a)
            2'd0:    lane8 = dm_rdata[31:24];
            2'd1:    lane8 = dm_rdata[23:16];
            2'd2:    lane8 = dm_rdata[15:8];
            default: lane8 = dm_rdata[7:0];
        endcase
        lane16 = a[1] ? dm_rdata[15:0] : dm_rdata[31:16];
        case (size_mem)
            2'b00: begin
                be    = 4'b1000 >> a;
                wdata = {4{st_data_mem[7:0]}};
                ext   = se_mem ? {{24{lane8[7]}}, lane8} : {24'b0, lane8};
            end
            2'b01: begin
                be    = a[1] ? 4'b0011 : 4'b1100;
                wdata = {2{st_data_mem[15:0]}};
                ext   = se_mem ? {{16{lane16[15]}}, lane16} : {16'b0, lane16};
            end
            default: begin
                be    = 4'b1111;
                wdata = st_data_mem;
                ext   = dm_rdata;
            end
        endcase
    end

    always_comb begin
        state_next  = state;
        stall_mem   = 1'b0;
        issue       = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            S_IDLE: begin
                if (E_mem && !misalign) begin
                    stall_mem  = 1'b1;
                    issue      = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dm_ack) begin
                    state_next = S_IDLE;
                end else if (timer == TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = S_IDLE;
                end else begin
                    stall_mem = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign trap_now = (state == S_IDLE) && E_mem && misalign;

    always_ff @(posedge clk) begin
        if (!R) begin
            state         <= S_IDLE;
            timer         <= '0;
            dm_req        <= 1'b0;
            dm_we         <= 1'b0;
            dm_addr       <= '0;
            dm_be         <= '0;
            dm_wdata      <= '0;
            wb_rf_le      <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            trap_misalign <= 1'b0;
            err_bus       <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_WAIT && state_next == S_WAIT)
                timer <= timer + 8'd1;
            else
                timer <= '0;

            if (issue) begin
                dm_req   <= 1'b1;
                dm_we    <= rw_dm_mem;
                dm_addr  <= alu_out_mem[ADDR_W-1:2];
                dm_be    <= be;
                dm_wdata <= wdata;
            end else if (state == S_WAIT && state_next == S_IDLE) begin
                dm_req <= 1'b0;
                dm_we  <= 1'b0;
            end

            // A stalled stage feeds a bubble; traps and bus errors suppress the RF write.
            if (!stall_mem) begin
                wb_rd    <= mem_rd;
                wb_rf_le <= rf_le_mem & ~trap_now & ~timeout_hit;
                wb_data  <= load_mem ? ext : alu_out_mem;
            end else begin
                wb_rf_le <= 1'b0;
            end

            trap_misalign <= trap_now;
            err_bus       <= timeout_hit;
        end
    end

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Directed self-checking bench for mem_stage_access_unit (default ADDR_W=9, TIMEOUT=15).
module tb_mem_stage_access_unit;

    logic        clk = 1'b0;
    logic        R, E_mem, rw_dm_mem, se_mem, load_mem, rf_le_mem, dm_ack;
    logic [1:0]  size_mem;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] alu_out_mem, st_data_mem, dm_rdata, dm_wdata, wb_data;
    logic        dm_req, dm_we, stall_mem, wb_rf_le, trap_misalign, err_bus;
    logic [6:0]  dm_addr;
    logic [3:0]  dm_be;

    int npass = 0;
    int nfail = 0;
    int ntotal = 0;

    mem_stage_access_unit #(.ADDR_W(9), .TIMEOUT(15)) dut (
        .clk(clk), .R(R), .E_mem(E_mem), .rw_dm_mem(rw_dm_mem), .size_mem(size_mem),
        .se_mem(se_mem), .load_mem(load_mem), .rf_le_mem(rf_le_mem), .mem_rd(mem_rd),
        .alu_out_mem(alu_out_mem), .st_data_mem(st_data_mem), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
        .dm_rdata(dm_rdata), .stall_mem(stall_mem), .wb_rf_le(wb_rf_le), .wb_rd(wb_rd),
        .wb_data(wb_data), .trap_misalign(trap_misalign), .err_bus(err_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_acc(input logic e, input logic rw, input logic [1:0] sz, input logic se,
                           input logic ld, input logic le, input logic [4:0] rd,
                           input logic [31:0] addr, input logic [31:0] st);
        E_mem = e; rw_dm_mem = rw; size_mem = sz; se_mem = se; load_mem = ld;
        rf_le_mem = le; mem_rd = rd; alu_out_mem = addr; st_data_mem = st;
    endtask

    initial begin
        int n;
        int stalls;
        int updates;

        R = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
        set_acc(0, 0, 2'b00, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        tick(); tick();
        check("rst_dm_req", 32'(dm_req), 32'h0);
        check("rst_dm_we", 32'(dm_we), 32'h0);
        check("rst_dm_be", 32'(dm_be), 32'h0);
        check("rst_dm_addr", 32'(dm_addr), 32'h0);
        check("rst_dm_wdata", dm_wdata, 32'h0);
        check("rst_wb", {wb_data[31:7] | 25'(wb_rd), wb_rf_le, trap_misalign, err_bus, 4'b0}, 32'h0);
        check("rst_stall", 32'(stall_mem), 32'h0);
        R = 1'b1;

        // Word load, ack on the first WAIT cycle
        set_acc(1, 0, 2'b10, 0, 1, 1, 5'd5, 32'h010, 32'h0);
        #1 check("wl_stall_idle", 32'(stall_mem), 32'h1);
        check("wl_req_idle", 32'(dm_req), 32'h0);
        tick();
        check("wl_req", 32'(dm_req), 32'h1);
        check("wl_addr", 32'(dm_addr), 32'h04);
        check("wl_be", 32'(dm_be), 32'hF);
        check("wl_we", 32'(dm_we), 32'h0);
        dm_ack = 1'b1; dm_rdata = 32'hDEADBEEF;
        #1 check("wl_stall_ack", 32'(stall_mem), 32'h0);
        tick();
        dm_ack = 1'b0;
        set_acc(0, 0, 2'b00, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        check("wl_wb_rd", 32'(wb_rd), 32'd5);
        check("wl_wb_data", wb_data, 32'hDEADBEEF);
        check("wl_wb_le", 32'(wb_rf_le), 32'h1);
        check("wl_req_drop", 32'(dm_req), 32'h0);

        // Byte load at offset 3, sign- then zero-extended
        set_acc(1, 0, 2'b00, 1, 1, 1, 5'd7, 32'h013, 32'h0);
        tick();
        check("bl_be", 32'(dm_be), 32'h1);
        dm_ack = 1'b1; dm_rdata = 32'h123456F0;
        tick();
        dm_ack = 1'b0;
        set_acc(0, 0, 2'b00, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        check("bl_se_data", wb_data, 32'hFFFFFFF0);
        set_acc(1, 0, 2'b00, 0, 1, 1, 5'd7, 32'h013, 32'h0);
        tick();
        dm_ack = 1'b1;
        tick();
        dm_ack = 1'b0;
        set_acc(0, 0, 2'b00, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        check("bl_ze_data", wb_data, 32'h000000F0);

        // Halfword store with rf_le_mem=0
        set_acc(1, 1, 2'b01, 0, 0, 0, 5'd2, 32'h102, 32'h0000ABCD);
        tick();
        check("hs_we", 32'(dm_we), 32'h1);
        check("hs_be", 32'(dm_be), 32'h3);
        check("hs_wdata", dm_wdata, 32'hABCDABCD);
        check("hs_addr", 32'(dm_addr), 32'h40);
        dm_ack = 1'b1;
        tick();
        dm_ack = 1'b0;
        set_acc(0, 0, 2'b00, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        check("hs_wb_le", 32'(wb_rf_le), 32'h0);
        check("hs_wb_data", wb_data, 32'h00000102);
        check("hs_we_drop", 32'(dm_we), 32'h0);

        // Ack delayed by 4 WAIT cycles
        set_acc(1, 0, 2'b10, 0, 1, 1, 5'd3, 32'h020, 32'h0);
        dm_rdata = 32'h0BADF00D;
        stalls = 0; updates = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) dm_ack = 1'b1;
            #1;
            if (stall_mem) stalls++;
            tick();
            if (wb_rf_le) updates++;
            dm_ack = 1'b0;
        end
        set_acc(0, 0, 2'b00, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        check("dly_stall_cycles", 32'(stalls), 32'd5);
        check("dly_updates", 32'(updates), 32'd1);
        check("dly_wb_data", wb_data, 32'h0BADF00D);

        // Ack withheld: bus-error abort after 15 WAIT cycles
        set_acc(1, 0, 2'b10, 0, 1, 1, 5'd9, 32'h030, 32'h0);
        tick();
        n = 0;
        while (!err_bus && n < 40) begin
            tick();
            n++;
        end
        check("to_wait_cycles", 32'(n), 32'd15);
        check("to_err_bus", 32'(err_bus), 32'h1);
        check("to_req", 32'(dm_req), 32'h0);
        check("to_wb_le", 32'(wb_rf_le), 32'h0);

        // ALU pass-through with E_mem=0
        set_acc(0, 0, 2'b00, 0, 0, 1, 5'd12, 32'h12345678, 32'h0);
        #1 check("alu_stall", 32'(stall_mem), 32'h0);
        tick();
        check("to_err_pulse", 32'(err_bus), 32'h0);
        check("alu_wb_data", wb_data, 32'h12345678);
        check("alu_wb_le", 32'(wb_rf_le), 32'h1);
        check("alu_wb_rd", 32'(wb_rd), 32'd12);
        check("alu_req", 32'(dm_req), 32'h0);

        // Misaligned word at 0x006
        set_acc(1, 0, 2'b10, 0, 1, 1, 5'd4, 32'h006, 32'h0);
`ifdef MEM_ALIGN_TRAP_EN
        #1 check("mis_stall", 32'(stall_mem), 32'h0);
        tick();
        check("mis_trap", 32'(trap_misalign), 32'h1);
        check("mis_req", 32'(dm_req), 32'h0);
        check("mis_wb_le", 32'(wb_rf_le), 32'h0);
        set_acc(0, 0, 2'b00, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        tick();
        check("mis_trap_pulse", 32'(trap_misalign), 32'h0);
`else
        #1 check("mis_stall", 32'(stall_mem), 32'h1);
        tick();
        check("mis_req", 32'(dm_req), 32'h1);
        check("mis_addr", 32'(dm_addr), 32'h01);
        check("mis_be", 32'(dm_be), 32'hF);
        dm_ack = 1'b1; dm_rdata = 32'hCAFEF00D;
        tick();
        dm_ack = 1'b0;
        set_acc(0, 0, 2'b00, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        check("mis_trap", 32'(trap_misalign), 32'h0);
        check("mis_wb_data", wb_data, 32'hCAFEF00D);
        check("mis_wb_le", 32'(wb_rf_le), 32'h1);
`endif

        // Reset during WAIT, then a stray ack
        set_acc(1, 0, 2'b10, 0, 1, 1, 5'd6, 32'h040, 32'h0);
        tick();
        check("rw_req_wait", 32'(dm_req), 32'h1);
        R = 1'b0;
        tick();
        R = 1'b1;
        check("rw_req", 32'(dm_req), 32'h0);
        check("rw_wb_le", 32'(wb_rf_le), 32'h0);
        check("rw_wb_data", wb_data, 32'h0);
        check("rw_wb_rd", 32'(wb_rd), 32'h0);
        set_acc(0, 0, 2'b00, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        dm_ack = 1'b1; dm_rdata = 32'hFFFFFFFF;
        #1 check("stray_stall", 32'(stall_mem), 32'h0);
        tick();
        dm_ack = 1'b0;
        check("stray_req", 32'(dm_req), 32'h0);
        check("stray_wb_le", 32'(wb_rf_le), 32'h0);
        check("stray_wb_data", wb_data, 32'h0);
        check("stray_err", 32'(err_bus), 32'h0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
